// File: rtl/ef_spi_pkg.sv
// Shared FSM state type and default widths for the EF_SPI transfer engine.
package ef_spi_pkg;

  localparam int DW_DEFAULT  = 32;
  localparam int CDW_DEFAULT = 8;
  localparam int NCS_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    NEXT,
    HOLD,
    GAP
  } state_e;

endpackage

// File: rtl/ef_spi_clkgen.sv
// Half-period prescaler for the SPI engine: one tick every divider_i+1 clocks.
module ef_spi_clkgen
  import ef_spi_pkg::*;
#(
  parameter int CDW = CDW_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  input  logic [CDW-1:0] divider_i,
  output logic           tick_o
);

  logic [CDW-1:0] count_q;

  assign tick_o = !clear_i && (count_q == divider_i);

  // Held at zero while cleared so the first half-period after a clear is full length.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i || tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ef_spi_xfer.sv
// SPI master engine: variable word length, multi-word frames, one-hot chip
// selects, selectable bit order and SPI mode, valid/ready TX stream.
module ef_spi_xfer
  import ef_spi_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int CDW = CDW_DEFAULT,
  parameter int NCS = NCS_DEFAULT,
  parameter int WLW = $clog2(DW)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           enable_i,
  input  logic           cpol_i,
  input  logic           cpha_i,
  input  logic           lsb_first_i,
  input  logic [CDW-1:0] clk_divider_i,
  input  logic [NCS-1:0] cs_mask_i,
  input  logic [WLW-1:0] word_len_i,
  input  logic [DW-1:0]  tx_data_i,
  input  logic           tx_last_i,
  input  logic           tx_valid_i,
  output logic           tx_ready_o,
  output logic [DW-1:0]  rx_data_o,
  output logic           rx_valid_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           sclk_o,
  output logic           mosi_o,
  input  logic           miso_i,
  output logic [NCS-1:0] csb_o
);

  state_e         state_q;
  logic           cpha_q, lsbFirst_q, last_q;
  logic           sclk_q, mosi_q, rxValid_q, done_q;
  logic [CDW-1:0] divider_q;
  logic [NCS-1:0] csb_q;
  logic [WLW-1:0] wordLen_q;
  logic [WLW:0]   edgeCnt_q;
  logic [DW-1:0]  txWord_q, rxWord_q, rxData_q;

  logic           tick, accept_d, trailing_d, lastEdge_d, sampleNow_d, driveNow_d, loadLsb_d;
  logic [WLW-1:0] bitIdx_d, drivePos_d, loadPos_d;
  logic [DW-1:0]  rxNext_d;

  function automatic logic [WLW-1:0] bitPos(input logic [WLW-1:0] k,
                                            input logic [WLW-1:0] len,
                                            input logic           lsb);
    return lsb ? k : len - k;
  endfunction

  ef_spi_clkgen #(.CDW(CDW)) u_clkgen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  ((state_q == IDLE) || (state_q == NEXT)),
    .divider_i(divider_q),
    .tick_o   (tick)
  );

  assign accept_d   = enable_i && tx_valid_i && ((state_q == IDLE) || (state_q == NEXT));
  assign tx_ready_o = rst_ni && accept_d;
  assign busy_o     = (state_q != IDLE);
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign csb_o      = csb_q;
  assign rx_data_o  = rxData_q;
  assign rx_valid_o = rxValid_q;
  assign done_o     = done_q;

  // Edge counter is {bit index, phase}: even edges lead, odd edges trail.
  always_comb begin
    bitIdx_d    = edgeCnt_q[WLW:1];
    trailing_d  = edgeCnt_q[0];
    lastEdge_d  = (edgeCnt_q == {wordLen_q, 1'b1});
    sampleNow_d = tick && (state_q == SHIFT) && (trailing_d == cpha_q);
    driveNow_d  = cpha_q ? !trailing_d : (trailing_d && (bitIdx_d != wordLen_q));
    drivePos_d  = bitPos(cpha_q ? bitIdx_d : bitIdx_d + WLW'(1), wordLen_q, lsbFirst_q);
    rxNext_d    = rxWord_q;
    if (sampleNow_d) begin
      rxNext_d[bitPos(bitIdx_d, wordLen_q, lsbFirst_q)] = miso_i;
    end
    loadLsb_d = (state_q == IDLE) ? lsb_first_i : lsbFirst_q;
    loadPos_d = loadLsb_d ? '0 : word_len_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cpha_q     <= 1'b0;
      lsbFirst_q <= 1'b0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rxValid_q  <= 1'b0;
      done_q     <= 1'b0;
      divider_q  <= '0;
      csb_q      <= '1;
      wordLen_q  <= '0;
      edgeCnt_q  <= '0;
      txWord_q   <= '0;
      rxWord_q   <= '0;
      rxData_q   <= '0;
    end else begin
      rxValid_q <= 1'b0;
      done_q    <= 1'b0;
      if (!enable_i) begin
        state_q <= IDLE;
        csb_q   <= '1;
        sclk_q  <= cpol_i;
      end else if (accept_d) begin
        // Frame-wide settings are captured only on the first word of a frame.
        if (state_q == IDLE) begin
          cpha_q     <= cpha_i;
          lsbFirst_q <= lsb_first_i;
          divider_q  <= clk_divider_i;
          csb_q      <= ~cs_mask_i;
          sclk_q     <= cpol_i;
        end
        txWord_q  <= tx_data_i;
        wordLen_q <= word_len_i;
        last_q    <= tx_last_i;
        mosi_q    <= tx_data_i[loadPos_d];
        rxWord_q  <= '0;
        edgeCnt_q <= '0;
        state_q   <= SETUP;
      end else begin
        unique case (state_q)
          IDLE: begin
            sclk_q <= cpol_i;
            csb_q  <= '1;
          end
          SETUP: if (tick) state_q <= SHIFT;
          SHIFT: if (tick) begin
            sclk_q    <= ~sclk_q;
            edgeCnt_q <= edgeCnt_q + 1'b1;
            rxWord_q  <= rxNext_d;
            if (driveNow_d) mosi_q <= txWord_q[drivePos_d];
            if (lastEdge_d) begin
              rxData_q  <= rxNext_d;
              rxValid_q <= 1'b1;
              state_q   <= last_q ? HOLD : NEXT;
            end
          end
          NEXT: ;
          HOLD: if (tick) begin
            csb_q   <= '1;
            state_q <= GAP;
          end
          GAP: if (tick) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ef_spi_xfer.md
Name: ef_spi_xfer

Overview:
Parametrised SPI master engine, the next generation of the EF_SPI shift core. Adds variable word length up to DW bits, multi-word frames with chip-select held across words, NCS one-hot chip selects, LSB/MSB-first order, and a valid/ready TX stream. Sits between the TX/RX aucohl_fifo pair and the pads, replacing the fixed 8-bit spi_master.

Parameters:
DW, 32, maximum word width in bits (2..32)
CDW, 8, clock-divider width
NCS, 4, number of chip-select outputs
WLW, $clog2(DW), word-length field width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  engine enable; low aborts any transfer
cpol  in  1  SCLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first  in  1  bit order
clk_divider  in  CDW  half-period = clk_divider+1 clk cycles
cs_mask  in  NCS  chip selects asserted for the frame
word_len  in  WLW  bits per word minus 1
tx_data  in  DW  word to send, right-aligned
tx_last  in  1  word is last of frame
tx_valid  in  1  TX word available
tx_ready  out  1  word accepted this cycle
rx_data  out  DW  received word, right-aligned, upper bits zero
rx_valid  out  1  one-cycle pulse, rx_data valid
busy  out  1  frame in progress (CS asserted or gap)
done  out  1  one-cycle pulse at frame end
sclk  out  1  SPI clock
mosi  out  1  serial out
miso  in  1  serial in
csb  out  NCS  active-low chip selects

Behaviour:
- Reset: csb all 1, sclk 0, mosi 0, tx_ready 0, rx_valid 0, done 0, busy 0, rx_data 0, state IDLE.
- Tick: prescaler counts 0..clk_divider, tick on terminal count; cleared on leaving IDLE. clk_divider=0 gives SCLK = clk/2.
- IDLE: sclk follows cpol (registered), csb all 1. When enable & tx_valid: tx_ready=1 for that cycle; latch tx_data, tx_last, word_len, cpol, cpha, lsb_first, cs_mask, clk_divider; go to SETUP. Frame config is frozen until the frame ends; word_len is re-latched per word.
- SETUP: csb = ~cs_mask; first bit driven on mosi; hold 1 half-period, then go to SHIFT.
- SHIFT: 2*(word_len+1) SCLK edges, one per tick. CPHA=0: leading edge samples miso, trailing edge shifts mosi. CPHA=1: leading edge shifts, trailing edge samples. MSB-first sends bit word_len..0; LSB-first sends 0..word_len. RX is assembled right-aligned into the same order.
- After the last edge, rx_data updates and rx_valid pulses in the same cycle. Then:
  - If the latched last flag is clear, go to NEXT: wait with CS held and sclk idle until tx_valid. Accept the word (tx_ready pulse), then 1 half-period setup, then SHIFT.
  - If the latched last flag is set, go to HOLD: 1 half-period with CS held, then csb all 1 and go to GAP.
- GAP: 1 half-period with csb high; done pulses on exit; return to IDLE. busy is 1 in every state except IDLE.
- tx_ready is never asserted outside the IDLE/NEXT acceptance cycle.
- enable low in any state: next cycle state=IDLE, csb all 1, sclk=cpol, no rx_valid, no done; the partial word is discarded.
- cs_mask=0: the frame runs normally with no CS asserted (legal).
- word_len=0: 1-bit words.
- Configuration changes mid-frame have no effect.

Decomposition:
- Package ef_spi_pkg holds the state enum (IDLE, SETUP, SHIFT, NEXT, HOLD, GAP) and the width helper localparams.
- One natural sub-module: ef_spi_clkgen (prescaler plus tick generation, clear input).
- Shift/sample datapath and FSM stay in ef_spi_xfer.

Test Plan:
- Mode 0, MSB-first, clk_divider=1, word_len=7, tx_data=8'hA5 with tx_last, miso loopback -> mosi bits 1,0,1,0,0,1,0,1; rx_data=32'h000000A5; rx_valid then done; 16 SCLK edges at 2-clk half-periods.
- Mode 3, LSB-first, word_len=11, tx_data=12'h3C1, miso tied 1 -> mosi order 1,0,0,0,0,0,1,1,1,1,0,0; rx_data=32'h00000FFF; sclk idles high.
- Three-word frame (8'h11, 8'h22, 8'h33 last, cs_mask=4'b0100) with tx_valid gap of 20 cycles after the second word -> csb=4'b1011 continuously across all three words; 3 rx_valid, 1 done.
- enable dropped at the 5th SCLK edge of a 16-bit word -> next cycle csb=4'hF, busy=0, no rx_valid/done; a fresh frame afterwards completes correctly.
- word_len=0 and word_len=DW-1 (32'hDEADBEEF) loopback -> exact 1-bit and 32-bit echoes.
- rst_n asserted mid-SHIFT -> all outputs at reset values immediately, independent of clk.
